// File: rtl/yuu_common_sync_fifo_if.sv
// ----------------------------------------------------------------------------
// yuu_common_sync_fifo_if
//
// Purpose:
//   Bundles the producer, consumer and status signals of yuu_common_sync_fifo
//   so that the FIFO and its neighbours connect through one port.
//
// Signals:
//   flush         master -> fifo   synchronous clear of contents
//   in_valid      master -> fifo   producer word valid
//   in_ready      fifo -> master   FIFO accepts a word this cycle
//   in_data       master -> fifo   producer word, DATA_WIDTH bits
//   out_valid     fifo -> master   head word valid
//   out_ready     master -> fifo   consumer takes the head word this cycle
//   out_data      fifo -> master   head word, DATA_WIDTH bits
//   count         fifo -> master   occupancy 0..DEPTH, $clog2(DEPTH)+1 bits
//   full          fifo -> master   count == DEPTH
//   empty         fifo -> master   count == 0
//   almost_full   fifo -> master   count >= AF_LEVEL
//   almost_empty  fifo -> master   count <= AE_LEVEL
//
// Modports:
//   master : the side that produces and consumes words (drives the inputs)
//   slave  : the FIFO itself
// ----------------------------------------------------------------------------
interface yuu_common_sync_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count,
        output full,
        output empty,
        output almost_full,
        output almost_empty
    );
endinterface

// File: rtl/yuu_common_sync_fifo.sv
// ----------------------------------------------------------------------------
// yuu_common_sync_fifo
//
// Purpose:
//   Single-clock valid/ready FIFO with first-word fall-through. Sits between
//   a VIP monitor/driver front end and the consumers built on common_pkg,
//   absorbing producer bursts and presenting words strictly in order, along
//   with occupancy and threshold flags (1-bit, 0 = False, 1 = True).
//
// Ports:
//   clk   in    clock, all state changes on the rising edge
//   rst   in    asynchronous active-high reset; clears pointers and count
//   bus   slave yuu_common_sync_fifo_if carrying flush, the in_* producer
//               handshake, the out_* consumer handshake and the status
//               outputs count/full/empty/almost_full/almost_empty
//
// Parameters:
//   DATA_WIDTH  word width
//   DEPTH       number of entries, power of two, >= 2
//   AF_LEVEL    almost_full threshold (count >= AF_LEVEL), 1..DEPTH
//   AE_LEVEL    almost_empty threshold (count <= AE_LEVEL), 0..DEPTH-1
// ----------------------------------------------------------------------------
module yuu_common_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    yuu_common_sync_fifo_if.slave       bus
);

    // Index width into the storage array; pointers carry one extra wrap bit.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0] wr_ptr_q;
    logic [CW-1:0] wr_ptr_d;
    logic [CW-1:0] rd_ptr_q;
    logic [CW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    logic full_w;
    logic empty_w;
    logic push;
    logic pop;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // ------------------------------------------------------------------------
    // Flags from registered pointers only.
    // Same index with different wrap bits means the writer is a full lap
    // ahead of the reader.
    // ------------------------------------------------------------------------
    assign full_w  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_w = (wr_ptr_q == rd_ptr_q);

    // in_ready deliberately ignores out_ready: a full FIFO never accepts a
    // word on the strength of a same-cycle pop, which keeps out_ready off the
    // producer's timing path.
    assign bus.in_ready  = !full_w && !bus.flush;
    assign bus.out_valid = !empty_w;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Head word is forced to zero when nothing is valid so downstream logic
    // never sees stale storage contents.
    assign bus.out_data = bus.out_valid ? mem_q[rd_idx] : '0;

    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));

    // ------------------------------------------------------------------------
    // Next-state logic. flush overrides everything; a pop in the flush cycle
    // is dropped and no push can happen because in_ready is low.
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: not reset. Contents are only observable through rd_idx while
    // the FIFO is non-empty, and every such slot was written first.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx] <= bus.in_data;
        end
    end

`ifndef SYNTHESIS
    // ------------------------------------------------------------------------
    // Simulation-only protocol and configuration checks
    // ------------------------------------------------------------------------
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af_level
        $error("yuu_common_sync_fifo: AF_LEVEL out of range 1..DEPTH");
    end

    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae_level
        $error("yuu_common_sync_fifo: AE_LEVEL out of range 0..DEPTH-1");
    end

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("yuu_common_sync_fifo: DEPTH must be a power of two >= 2");
    end

    // A stalled producer must hold its word until it is taken (or withdrawn).
    a_in_data_stable : assert property (
        @(posedge clk) disable iff (rst)
        (bus.in_valid && !bus.in_ready) |=> (!bus.in_valid || $stable(bus.in_data))
    ) else $error("yuu_common_sync_fifo: in_data changed while stalled");
`endif

endmodule
